bus_op_sequencer: RTL
=====================

Name: bus_op_sequencer

Overview:
- Queues L2 bus-operation requests (Read, Write, Modify, Invalidate) from the L2 cache controller.
- Sequences them one at a time onto the shared system bus using a request/grant and valid/ack handshake.
- Reports completion of each operation back to the controller.
- Honours the global bus-operation enable: when disabled, operations retire locally with no bus activity.

Parameters:
ADDR_W, 32, width of the bus address (matches the cache address size)
DEPTH, 4, request FIFO entries (power of two, 2..16)
TIMEOUT, 15, maximum cycles spent in XFER waiting for bus_ack before an error retire (1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
bus_en  in  1  bus-operation enable; sampled in IDLE only
req_valid  in  1  controller presents a request
req_op  in  2  00=R, 01=W, 10=M, 11=I
req_addr  in  ADDR_W  request address
req_ready  out  1  FIFO can accept a request (= !full)
bus_req  out  1  bus request to the arbiter
bus_gnt  in  1  bus grant
bus_valid  out  1  op/addr on the bus are valid
bus_op  out  2  operation code, same encoding as req_op
bus_addr  out  ADDR_W  operation address
bus_ack  in  1  bus target accepted the operation
done_valid  out  1  one-cycle completion pulse
done_op  out  2  op code of the retired entry
done_addr  out  ADDR_W  address of the retired entry
done_err  out  1  retire was due to timeout
busy  out  1  FIFO non-empty or FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Output registers: all outputs except req_ready and busy are registered.
- Reset values: bus_req=0, bus_valid=0, bus_op=0, bus_addr=0, done_valid=0, done_op=0, done_addr=0, done_err=0.
- Reset effects: FIFO empty, so req_ready=1 and busy=0. FSM goes to IDLE and the timeout counter clears.
- Reset mid-operation: any in-flight or queued operation is discarded with no done pulse, and bus_req/bus_valid drop on the next edge.
- FIFO push: on req_valid && req_ready. req_ready is derived from the registered count.
- Push while full: never accepted, even in a cycle where a pop occurs.
- Simultaneous push and pop when not full: count is unchanged. Pointers wrap modulo DEPTH.
- FIFO pop: only on the DONE state cycle. The head entry is never changed while XFER is in progress.
- IDLE:
  - If FIFO is non-empty and bus_en=1, go to ARB and set bus_req=1.
  - If FIFO is non-empty and bus_en=0, go to DONE directly (bypass retire, done_err=0); bus_req, bus_valid and the bus signals stay 0.
- ARB:
  - Hold bus_req=1.
  - On sampled bus_gnt=1, go to XFER: bus_valid=1, bus_op/bus_addr = FIFO head, timeout counter cleared.
  - Waits indefinitely for grant.
- XFER:
  - bus_req and bus_valid are held; bus_op and bus_addr are stable.
  - The counter increments each cycle. Deassertion of bus_gnt during XFER is ignored.
  - On sampled bus_ack=1, go to DONE with done_err=0.
  - If counter == TIMEOUT with no ack, go to DONE with done_err=1.
  - Ack and timeout in the same cycle: ack wins (done_err=0).
- DONE (one cycle):
  - done_valid=1 with done_op/done_addr from the head.
  - bus_req=0, bus_valid=0. Pop the FIFO and return to IDLE.
- Back-to-back retires: consecutive operations have at least one IDLE cycle between done pulses.
- Latency: request accepted at edge N, into an empty FIFO with bus_en=1 and gnt tied high:
  - bus_req at N+2, bus_valid at N+3.
  - With ack at N+3, done_valid at N+4.
- Bypass latency: with bus_en=0, done_valid at N+2.
- Ordering: strictly FIFO. There is no reordering between op types.
- busy is combinational: (count != 0) || (state != IDLE).

Test Plan:
- Single R, addr 0x0000_1A40, bus_en=1, gnt tied 1, ack 1 cycle after bus_valid -> bus_op=00, bus_addr=0x0000_1A40 held until ack; one done pulse with done_op=00, done_err=0; busy drops the cycle after DONE.
- Push W 0x100, M 0x200, I 0x300, R 0x400 back-to-back with gnt held low -> req_ready=0 after the 4th push and a 5th push is ignored; on gnt, bus ops appear in the order W, M, I, R; done pulses are in the same order.
- bus_en=0, push R 0x40 and W 0x80 -> bus_req and bus_valid never assert; two done pulses 0x40 then 0x80, each with done_err=0.
- Grant given but ack never asserted, TIMEOUT=15 -> bus_valid high for exactly 16 cycles; done_err=1, done_op/done_addr match the entry; the next queued op then starts normally.
- Ack asserted on the same cycle the counter reaches 15 -> done_err=0.
- rst asserted during XFER with 2 entries queued -> next edge: bus_req=0, bus_valid=0, req_ready=1, busy=0, no done pulse; a new push after reset proceeds normally.

Source files
------------

// File: rtl/bus_op_sequencer.sv
// bus_op_sequencer: queues L2 bus-operation requests (R/W/M/I) in a
// small FIFO and issues them one at a time onto the shared system bus.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bus_en              bus-operation enable (sampled in IDLE only)
//   req_valid/req_ready request handshake from the L2 controller
//   req_op, req_addr    requested operation and address
//   bus_req/bus_gnt     arbitration handshake with the bus arbiter
//   bus_valid/bus_ack   transfer handshake with the bus target
//   bus_op, bus_addr    operation presented on the bus
//   done_valid          one-cycle retire pulse back to the controller
//   done_op, done_addr  operation and address of the retired entry
//   done_err            retire was caused by an ack timeout
//   busy                work queued or an operation in progress
//
// With bus_en low, queued operations retire locally without any bus
// activity. Operations retire strictly in request order.

module bus_op_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_en,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_valid,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    output logic              done_valid,
    output logic [1:0]        done_op,
    output logic [ADDR_W-1:0] done_addr,
    output logic              done_err,
    output logic              busy
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
    localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_XFER,
        S_DONE
    } state_t;

    state_t state, state_d;

    // ------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------
    logic [1:0]        op_mem   [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            head_vld;
    logic            push;
    logic            pop;

    logic [1:0]        head_op;
    logic [ADDR_W-1:0] head_addr;

    assign req_ready = (count != FULL);
    assign push      = req_valid && req_ready;
    assign pop       = (state == S_DONE);
    assign busy      = (count != '0) || (state != S_IDLE);

    // The head slot is not overwritten while occupied: a write to
    // rd_ptr would require a full FIFO, and full pushes are refused.
    assign head_op   = op_mem[rd_ptr];
    assign head_addr = addr_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]   <= req_op;
            addr_mem[wr_ptr] <= req_addr;
        end
    end

    // head_vld lags count by one cycle: the FSM only launches an
    // entry once it has been resident for a full cycle, and it is
    // cleared on every pop so the next head is re-qualified.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_vld <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                head_vld <= 1'b0;
            end else if (count != '0) begin
                head_vld <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------
    logic [TW-1:0]     tcnt;
    logic [TW-1:0]     tcnt_d;
    logic              bus_req_d;
    logic              bus_valid_d;
    logic [1:0]        bus_op_d;
    logic [ADDR_W-1:0] bus_addr_d;
    logic              done_valid_d;
    logic [1:0]        done_op_d;
    logic [ADDR_W-1:0] done_addr_d;
    logic              done_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tcnt       <= '0;
            bus_req    <= 1'b0;
            bus_valid  <= 1'b0;
            bus_op     <= '0;
            bus_addr   <= '0;
            done_valid <= 1'b0;
            done_op    <= '0;
            done_addr  <= '0;
            done_err   <= 1'b0;
        end else begin
            state      <= state_d;
            tcnt       <= tcnt_d;
            bus_req    <= bus_req_d;
            bus_valid  <= bus_valid_d;
            bus_op     <= bus_op_d;
            bus_addr   <= bus_addr_d;
            done_valid <= done_valid_d;
            done_op    <= done_op_d;
            done_addr  <= done_addr_d;
            done_err   <= done_err_d;
        end
    end

    always_comb begin
        state_d      = state;
        tcnt_d       = tcnt;
        bus_req_d    = bus_req;
        bus_valid_d  = bus_valid;
        bus_op_d     = bus_op;
        bus_addr_d   = bus_addr;
        done_valid_d = 1'b0;
        done_op_d    = done_op;
        done_addr_d  = done_addr;
        done_err_d   = done_err;

        unique case (state)
            S_IDLE: begin
                if (head_vld) begin
                    if (bus_en) begin
                        state_d   = S_ARB;
                        bus_req_d = 1'b1;
                    end else begin
                        // Local retire: no bus traffic at all.
                        state_d      = S_DONE;
                        done_valid_d = 1'b1;
                        done_op_d    = head_op;
                        done_addr_d  = head_addr;
                        done_err_d   = 1'b0;
                    end
                end
            end

            S_ARB: begin
                if (bus_gnt) begin
                    state_d     = S_XFER;
                    bus_valid_d = 1'b1;
                    bus_op_d    = head_op;
                    bus_addr_d  = head_addr;
                    tcnt_d      = '0;
                end
            end

            S_XFER: begin
                // Grant loss is ignored once the transfer started.
                // Ack is checked first so it wins over a timeout.
                if (bus_ack || (tcnt == TMAX)) begin
                    state_d      = S_DONE;
                    bus_req_d    = 1'b0;
                    bus_valid_d  = 1'b0;
                    done_valid_d = 1'b1;
                    done_op_d    = head_op;
                    done_addr_d  = head_addr;
                    done_err_d   = !bus_ack;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
